uart_frame_rx: RTL
==================

// Module: uart_frame_rx
// PURPOSE
//  Parametrised UART frame receiver: oversampled RX front end plus a byte assembler that packs
//  FRAME_BYTES consecutive bytes into one frame word, qualified by a single-cycle valid pulse.
//  Replaces the fixed 2-byte receiver + external baud generator pair; the baud tick is internal.
//  Sits between the board RX pin and the command decoder / transmitter. First byte is the command.
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency (Hz)
//  BAUD          9600        line rate (bit/s)
//  OVERSAMPLE    16          samples per bit; even, >= 8
//  FRAME_BYTES   2           bytes per frame, >= 1
//  TIMEOUT_BITS  20          idle bit-times after a partial frame before it is discarded
// PORTS
//  clk          in   1                 system clock, rising edge
//  rst_n        in   1                 async reset, active low
//  rx           in   1                 UART RX line, idle high, asynchronous
//  frame_data   out  8*FRAME_BYTES     assembled frame; byte 0 in [8*FRAME_BYTES-1 -: 8]
//  frame_valid  out  1                 1-cycle pulse: frame_data updated this cycle
//  frame_err    out  1                 1-cycle pulse: stop/parity error or timeout, frame dropped
//  busy         out  1                 high while a byte or partial frame is in progress
// BEHAVIOUR
//  - Reset: frame_data=0, frame_valid=0, frame_err=0, busy=0, FSM=IDLE, byte_idx=0, sync FFs=1.
//  - rx passes a 2-FF synchroniser; all decisions use synchronised value.
//  - Tick: DIV=CLK_HZ/(BAUD*OVERSAMPLE) (integer, min 1); counter 0..DIV-1, tick when it wraps.
//    Counter free-runs; resynchronised to 0 on start-edge detection.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP.
//    IDLE : falling edge on synced rx -> START, sample cnt=0.
//    START: at sample OVERSAMPLE/2-1, rx still 0 -> DATA; rx 1 -> IDLE (glitch, no error).
//    DATA : 8 bits LSB first, each sampled at mid-bit (OVERSAMPLE ticks apart) -> STOP after bit 7.
//    STOP : sampled at mid-bit. rx=1 -> byte accepted; rx=0 -> frame_err, byte_idx=0, wait rx=1
//           then IDLE. No frame_valid on error.
//  - Assembly: byte k written to slot k (k=0 MSB slot) of a shadow register; frame_data updated
//    from shadow only when byte FRAME_BYTES-1 is accepted; frame_valid pulses same cycle as the
//    update (latency: 1 clk after last stop-bit sample). frame_data holds until next full frame.
//  - Timeout: in IDLE with byte_idx>0, count ticks; at TIMEOUT_BITS*OVERSAMPLE ticks ->
//    frame_err pulse, byte_idx=0, shadow discarded. Counter cleared on every start edge.
//  - Start edge in the same cycle as timeout expiry: start wins, no error, frame continues.
//  - busy = (FSM!=IDLE) | (byte_idx!=0).
//  - frame_valid and frame_err never assert in the same cycle.
//  - Reset mid-byte/mid-frame: everything cleared; no pulse emitted; next falling edge is byte 0.
//  - FRAME_BYTES=1: every good byte produces frame_valid; timeout logic unreachable.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state after DATA, even parity over 8 data bits sampled mid-bit;
//    mismatch -> frame_err, byte_idx=0, byte dropped; STOP still checked (stop error ignored
//    if parity already failed, one frame_err pulse only).
//  UART_PARITY_EN undefined: 8N1, no PARITY state, no parity logic synthesised.
// TESTING  (sim params CLK_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 -> DIV=1, 16 clk/bit)
//  1. 8N1 send 0xA5,0x3C back-to-back -> frame_data=16'hA53C, one frame_valid, frame_err=0.
//  2. 0x12, then idle 21 bit-times, then 0x34,0x56 -> one frame_err at 20 bit-times,
//     then frame_data=16'h3456 with one frame_valid.
//  3. rx low pulse of 4 clk while IDLE -> no pulses, busy returns 0, next frame 0xBEEF ok.
//  4. 0x77 with stop bit held 0 -> frame_err once, no frame_valid, next 0x01,0x02 -> 16'h0102.
//  5. rst_n low for 3 clk during bit 4 of byte 1 -> outputs 0; later 0xCAFE -> 16'hCAFE.
//  6. UART_PARITY_EN: 0x03 with parity=1 -> frame_err; 0x03,0x81 with parity 0,0 -> 16'h0381.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: oversampled UART receiver that packs FRAME_BYTES bytes into one frame word.
// Define UART_PARITY_EN for 8E1 framing with even parity; the default build is 8N1.
module uart_frame_rx #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned FRAME_BYTES  = 2,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int unsigned DIV_RAW  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W    = $clog2(OVERSAMPLE);
  localparam int unsigned HALF     = OVERSAMPLE / 2;
  localparam int unsigned IDX_W    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
  localparam int unsigned FW       = 8 * FRAME_BYTES;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       state_q, state_d;
  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [FW-1:0]    shadow_q, shadow_d, shadow_nxt;
  logic [FW-1:0]    frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             stop_wait_q, stop_wait_d;
  logic             tick, start_edge, par_ok;

`ifdef UART_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_ok = !par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign tick       = (div_cnt_q == DIV_W'(DIV - 1));
  assign start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_sync_q;

  always_comb begin
    // NOTE: every *_d is given its hold value first, so no branch of the case below can leave one unassigned and infer a latch.
    state_d       = state_q;
    smp_cnt_d     = smp_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_idx_d    = byte_idx_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    to_cnt_d      = to_cnt_q;
    stop_wait_d   = stop_wait_q;
`ifdef UART_PARITY_EN
    par_err_d     = par_err_q;
`endif

    // The baud divider restarts on a start edge so mid-bit sampling is aligned to that edge.
    if (start_edge || tick) div_cnt_d = '0;
    else                    div_cnt_d = div_cnt_q + DIV_W'(1);

    shadow_nxt = shadow_q;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (byte_idx_q == IDX_W'(k)) shadow_nxt[8*(FRAME_BYTES-1-k) +: 8] = shift_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d  = S_START;
          smp_cnt_d = '0;
          to_cnt_d = '0;
`ifdef UART_PARITY_EN
          par_err_d = 1'b0;
`endif
        end else if (byte_idx_q != '0) begin
          // A partial frame is abandoned once the line has been idle for too long.
          if (tick) begin
            if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
              frame_err_d = 1'b1;
              byte_idx_d  = '0;
              shadow_d    = '0;
              to_cnt_d    = '0;
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
        end else begin
          to_cnt_d = '0;
        end
      end

      S_START: begin
        if (tick) begin
          if (smp_cnt_q == SMP_W'(HALF - 1)) begin
            smp_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
            smp_cnt_d = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
            smp_cnt_d = '0;
            state_d   = S_STOP;
            if ((^shift_q) != rx_sync_q) begin
              par_err_d   = 1'b1;
              frame_err_d = 1'b1;
              byte_idx_d  = '0;
              shadow_d    = '0;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
      end
`endif

      S_STOP: begin
        if (stop_wait_q) begin
          // After a framing error, hold off until the line is back to idle.
          if (rx_sync_q) begin
            state_d     = S_IDLE;
            stop_wait_d = 1'b0;
          end
        end else if (tick) begin
          if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
            smp_cnt_d = '0;
            if (!rx_sync_q) begin
              stop_wait_d = 1'b1;
              if (par_ok) begin
                frame_err_d = 1'b1;
                byte_idx_d  = '0;
                shadow_d    = '0;
              end
            end else begin
              state_d = S_IDLE;
              if (par_ok) begin
                if (byte_idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                  frame_data_d  = shadow_nxt;
                  frame_valid_d = 1'b1;
                  byte_idx_d    = '0;
                  shadow_d      = '0;
                end else begin
                  shadow_d   = shadow_nxt;
                  byte_idx_d = byte_idx_q + IDX_W'(1);
                end
              end
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      div_cnt_q     <= '0;
      state_q       <= S_IDLE;
      smp_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_idx_q    <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      to_cnt_q      <= '0;
      stop_wait_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      div_cnt_q     <= div_cnt_d;
      state_q       <= state_d;
      smp_cnt_q     <= smp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_idx_q    <= byte_idx_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      to_cnt_q      <= to_cnt_d;
      stop_wait_q   <= stop_wait_d;
`ifdef UART_PARITY_EN
      par_err_q     <= par_err_d;
`endif
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != S_IDLE) || (byte_idx_q != '0);

endmodule
